// File: rtl/nw_pkg.sv
// Shared types and constants for the Needleman-Wunsch grid and its job sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nw_pkg;

    // Sequencer phases; the numeric values are shared with Grid-side debug tooling
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Traceback direction codes produced by the grid cells
    localparam logic [1:0] DIR_TOP    = 2'd0;
    localparam logic [1:0] DIR_LEFT   = 2'd1;
    localparam logic [1:0] DIR_CORNER = 2'd2;

    // Default scoring weights
    localparam int MATCH_W    = 1;
    localparam int INDEL_W    = -1;
    localparam int MISMATCH_W = -1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nw_rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping, as a one-hot grant.
// Latency: purely combinational.
// Backpressure: no grant at all while enable is low.
module nw_rr_arbiter
    import nw_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            enable,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic           found;
    logic [IDW-1:0] idx;

    // Walk the requesters starting at ptr and stop at the first one asking
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NREQ);
            if (enable && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/nw_job_sequencer.sv
// Front-end for the NW grid: arbitrates jobs, loads strings, sequences clear/run, returns the score.
// Latency: grant to rsp_valid = 1 + CLEAR_CYCLES + cycles until grid_valid (capped by TIMEOUT).
// Backpressure: one job in flight; no req_ready until the response has handshaked.
module nw_job_sequencer
    import nw_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int LENGTH       = 10,
    parameter int CWIDTH       = 2,
    parameter int SWIDTH       = 16,
    parameter int CLEAR_CYCLES = 2,
    parameter int TIMEOUT      = 4*LENGTH + 16,
    parameter int IDW          = $clog2(NREQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*LENGTH*CWIDTH-1:0] req_s1,
    input  logic [NREQ*LENGTH*CWIDTH-1:0] req_s2,
    output logic                          grid_reset,
    output logic [LENGTH*CWIDTH-1:0]      grid_s1,
    output logic [LENGTH*CWIDTH-1:0]      grid_s2,
    input  logic [SWIDTH-1:0]             grid_score,
    input  logic                          grid_valid,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [IDW-1:0]                rsp_id,
    output logic [SWIDTH-1:0]             rsp_score,
    output logic                          rsp_timeout,
    output logic                          busy
);

    localparam int SW   = LENGTH * CWIDTH;
    localparam int CNTW = $clog2(max2(TIMEOUT, CLEAR_CYCLES) + 1);
    localparam logic [CNTW-1:0] CLR_LAST = CNTW'(CLEAR_CYCLES - 1);
    localparam logic [CNTW-1:0] RUN_LAST = CNTW'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [SW-1:0]     s1_q, s1_d, s2_q, s2_d;
    logic [SWIDTH-1:0] score_q, score_d;
    logic              tmo_q, tmo_d;
    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    gnt_id;
    logic [SW-1:0]     s1_arr [NREQ];
    logic [SW-1:0]     s2_arr [NREQ];

    // Per-requester views of the packed string buses
    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign s1_arr[g] = req_s1[g*SW +: SW];
        assign s2_arr[g] = req_s2[g*SW +: SW];
    end

    nw_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .enable (state_q == IDLE),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready   = gnt;
    assign grid_reset  = (state_q == IDLE) || (state_q == CLEAR);
    assign grid_s1     = s1_q;
    assign grid_s2     = s2_q;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_id      = id_q;
    assign rsp_score   = score_q;
    assign rsp_timeout = tmo_q;
    assign busy        = (state_q != IDLE);

    // Next-state and datapath updates for the job phases
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        score_d  = score_q;
        tmo_d    = tmo_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    s1_d     = s1_arr[gnt_id];
                    s2_d     = s2_arr[gnt_id];
                    id_d     = gnt_id;
                    rr_ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
                    cnt_d    = '0;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                // grid_valid may still be high from the previous job here, so it is not looked at
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CLR_LAST) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNTW'(1);
                if (grid_valid) begin
                    score_d = grid_score;
                    tmo_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == RUN_LAST) begin
                    score_d = '0;
                    tmo_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any job without a response
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            id_q     <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            score_q  <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            score_q  <= score_d;
            tmo_q    <= tmo_d;
        end
    end

endmodule

// File: tb/tb_nw_job_sequencer.sv
// Bench for nw_job_sequencer: random and directed jobs, a grid model, and a scoreboard monitor.
// Latency: expected response cycle is computed per job from grant time and grid delay.
// Backpressure: rsp_ready is held low or randomised to exercise response stalls.
module tb_nw_job_sequencer;

    localparam int NREQ         = 4;
    localparam int LENGTH       = 10;
    localparam int CWIDTH       = 2;
    localparam int SWIDTH       = 16;
    localparam int CLEAR_CYCLES = 2;
    localparam int TIMEOUT      = 4*LENGTH + 16;
    localparam int SW           = LENGTH * CWIDTH;
    localparam int NEVER        = 1000;
    localparam int FOREVER_BUSY = 2147483647;

    logic                   clk;
    logic                   reset;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*SW-1:0]     req_s1;
    logic [NREQ*SW-1:0]     req_s2;
    logic                   grid_reset;
    logic [SW-1:0]          grid_s1;
    logic [SW-1:0]          grid_s2;
    logic [SWIDTH-1:0]      grid_score;
    logic                   grid_valid;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_id;
    logic [SWIDTH-1:0]      rsp_score;
    logic                   rsp_timeout;
    logic                   busy;

    nw_job_sequencer #(
        .NREQ(NREQ), .LENGTH(LENGTH), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH),
        .CLEAR_CYCLES(CLEAR_CYCLES), .TIMEOUT(TIMEOUT), .IDW(2)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_s1(req_s1), .req_s2(req_s2), .grid_reset(grid_reset),
        .grid_s1(grid_s1), .grid_s2(grid_s2), .grid_score(grid_score),
        .grid_valid(grid_valid), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_score(rsp_score), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [15:0] score;
        bit          tmo;
        int          rcyc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;

    // Requester-side pending jobs
    bit          pend   [NREQ];
    logic [SW-1:0] js1  [NREQ];
    logic [SW-1:0] js2  [NREQ];
    int          jd     [NREQ];
    logic [15:0] jscore [NREQ];
    bit          jstale [NREQ];

    // Reference model state
    int          mptr    = 0;
    int          free_at = 0;
    bit          cur_active = 0;
    logic [SW-1:0] cur_s1, cur_s2;
    int          cur_d;
    logic [15:0] cur_score;
    bit          cur_stale;
    int          gt = 0;
    bit          prev_gr = 1;
    int          run_k = 0;
    bit          in_resp = 0;

    // Scenario knobs
    int          rst_cycles = 0;
    int          bp_hold    = 0;
    int          rdy_mode   = 0;
    bit          rand_post  = 0;
    bit          got_grant  = 0;
    int          last_gid   = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic post(input int i, input logic [SW-1:0] a, input logic [SW-1:0] b,
                        input int d, input logic [15:0] sc, input bit st);
        pend[i]   = 1'b1;
        js1[i]    = a;
        js2[i]    = b;
        jd[i]     = d;
        jscore[i] = sc;
        jstale[i] = st;
    endtask

    function automatic int rnd_d();
        case ($urandom_range(7))
            0:       return NEVER;
            1:       return TIMEOUT - 1;
            2:       return TIMEOUT;
            3:       return 0;
            default: return int'($urandom_range(40));
        endcase
    endfunction

    task automatic post_rand(input int i, input int d);
        post(i, SW'($urandom), SW'($urandom), d, 16'($urandom), bit'($urandom_range(1)));
    endtask

    // First requester asking, searching upward from the model pointer with wrap
    function automatic int pick_grant();
        for (int off = 0; off < NREQ; off++) begin
            if (req_valid[(mptr + off) % NREQ]) return (mptr + off) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < NREQ; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive all inputs at the falling edge, then check and update the model
    task automatic step();
        int   eg;
        exp_t e;
        @(negedge clk);
        if (rand_post) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend[i] && $urandom_range(3) == 0) post_rand(i, rnd_d());
        end
        // Grid model: result after cur_d RUN cycles; stale valid possible while held in reset
        if (grid_reset === 1'b0) begin
            run_k = prev_gr ? 0 : run_k + 1;
            if (cur_active && run_k >= cur_d) begin
                grid_valid = 1'b1;
                grid_score = cur_score;
            end else begin
                grid_valid = 1'b0;
                grid_score = 16'($urandom);
            end
            prev_gr = 1'b0;
        end else begin
            run_k      = 0;
            grid_valid = cur_active ? cur_stale : bit'($urandom_range(1));
            grid_score = cur_score ^ 16'h5a5a;
            prev_gr    = 1'b1;
        end
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = pend[i];
            req_s1[i*SW +: SW]    = js1[i];
            req_s2[i*SW +: SW]    = js2[i];
        end
        if (rsp_valid === 1'b1 && bp_hold > 0) begin
            rsp_ready = 1'b0;
            bp_hold--;
        end else begin
            rsp_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
        end
        reset = (rst_cycles > 0) ? 1'b0 : 1'b1;
        #1;
        if (!reset) begin
            rst_cycles--;
            sb.delete();
            mptr       = 0;
            free_at    = cyc + 1;
            cur_active = 1'b0;
            in_resp    = 1'b0;
        end else begin
            eg = (cyc >= free_at) ? pick_grant() : -1;
            chk("req_ready", 64'(req_ready), (eg >= 0) ? (64'd1 << eg) : 64'd0);
            if (eg >= 0) begin
                got_grant  = 1'b1;
                last_gid   = eg;
                gt         = cyc;
                free_at    = FOREVER_BUSY;
                mptr       = (eg + 1) % NREQ;
                pend[eg]   = 1'b0;
                cur_active = 1'b1;
                cur_s1     = js1[eg];
                cur_s2     = js2[eg];
                cur_d      = jd[eg];
                cur_score  = jscore[eg];
                cur_stale  = jstale[eg];
                e.id = eg;
                if (cur_d <= TIMEOUT - 1) begin
                    e.score = cur_score;
                    e.tmo   = 1'b0;
                    e.rcyc  = gt + CLEAR_CYCLES + 2 + cur_d;
                end else begin
                    e.score = 16'd0;
                    e.tmo   = 1'b1;
                    e.rcyc  = gt + 1 + CLEAR_CYCLES + TIMEOUT;
                end
                sb.push_back(e);
            end
            if (cur_active && cyc == gt + CLEAR_CYCLES) begin
                chk("grid_reset_in_clear", 64'(grid_reset), 64'd1);
                chk("busy_in_clear", 64'(busy), 64'd1);
            end
            if (cur_active && cyc == gt + CLEAR_CYCLES + 1) begin
                chk("grid_reset_in_run", 64'(grid_reset), 64'd0);
                chk("grid_s1", 64'(grid_s1), 64'(cur_s1));
                chk("grid_s2", 64'(grid_s2), 64'(cur_s2));
            end
        end
    endtask

    task automatic wait_idle(input int maxc);
        for (int n = 0; n < maxc; n++) begin
            if (sb.size() == 0 && !any_pend() && cyc >= free_at) return;
            step();
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard monitor: compares every presented response against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset === 1'b1 && rsp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got id %0d with empty scoreboard (cycle %0d)", rsp_id, cyc);
                end else begin
                    e = sb[0];
                    if (!in_resp) chk("rsp_latency", 64'(cyc), 64'(e.rcyc));
                    in_resp = 1'b1;
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_score", 64'(rsp_score), 64'(e.score));
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
                    if (rsp_ready === 1'b1) begin
                        void'(sb.pop_front());
                        in_resp = 1'b0;
                        free_at = cyc + 1;
                    end
                end
            end
        end
    end

    int rr_exp [9] = '{0, 1, 2, 3, 0, 2, 3, 0, 2};
    int order  [$];

    initial begin
        int grants;
        int guard;
        reset      = 1'b0;
        req_valid  = '0;
        req_s1     = '0;
        req_s2     = '0;
        grid_valid = 1'b0;
        grid_score = '0;
        rsp_ready  = 1'b0;

        // Reset state
        rst_cycles = 3;
        repeat (3) step();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_score", 64'(rsp_score), 64'd0);
        chk("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grid_reset", 64'(grid_reset), 64'd1);
        chk("rst_grid_s1", 64'(grid_s1), 64'd0);
        chk("rst_grid_s2", 64'(grid_s2), 64'd0);

        // Round-robin with all requesters held; requester 1 stops after its first grant
        for (int i = 0; i < NREQ; i++) post_rand(i, 2);
        grants = 0;
        guard  = 0;
        while (grants < 9 && guard < 600) begin
            got_grant = 1'b0;
            step();
            guard++;
            if (got_grant) begin
                order.push_back(last_gid);
                grants++;
                if (last_gid != 1) post_rand(last_gid, 2);
            end
        end
        chk("rr_grant_count", 64'(grants), 64'd9);
        for (int k = 0; k < order.size() && k < 9; k++)
            chk("rr_order", 64'(order[k]), 64'(rr_exp[k]));
        wait_idle(1000);

        // Single job, requester 2, all-zero strings, result 30 cycles into RUN
        post(2, '0, '0, 29, 16'd10, 1'b0);
        wait_idle(300);

        // Backpressure: response stalled 20 cycles while others keep requesting
        bp_hold = 20;
        post(1, SW'($urandom), SW'($urandom), 5, 16'hFFFD, 1'b0);
        wait_idle(40);
        post_rand(0, 3);
        post_rand(3, 3);
        wait_idle(600);

        // Timeout, and the boundary where valid arrives on the last allowed cycle
        post(3, SW'($urandom), SW'($urandom), NEVER, 16'h1234, 1'b0);
        wait_idle(300);
        post(0, SW'($urandom), SW'($urandom), TIMEOUT - 1, 16'h0077, 1'b0);
        wait_idle(300);
        post(1, SW'($urandom), SW'($urandom), TIMEOUT, 16'h0088, 1'b0);
        wait_idle(300);

        // Stale grid_valid held through CLEAR
        post(2, SW'($urandom), SW'($urandom), 10, 16'hFF80, 1'b1);
        wait_idle(300);

        // Random traffic
        rand_post = 1'b1;
        rdy_mode  = 1;
        repeat (1500) step();
        rand_post = 1'b0;
        wait_idle(4000);

        // Reset in the middle of RUN
        rdy_mode = 0;
        post(3, SW'($urandom), SW'($urandom), NEVER, 16'h0001, 1'b0);
        guard = 0;
        while (!(cur_active && cyc == gt + CLEAR_CYCLES + 11) && guard < 300) begin
            step();
            guard++;
        end
        post_rand(1, 4);
        post_rand(3, 4);
        rst_cycles = 1;
        step();
        got_grant = 1'b0;
        step();
        chk("post_rst_grid_reset", 64'(grid_reset), 64'd1);
        chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_granted", 64'(got_grant), 64'd1);
        chk("post_rst_gid", 64'(last_gid), 64'd1);
        wait_idle(600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nw_job_sequencer.md
Name: nw_job_sequencer

Overview:
- Front-end controller for the Needleman-Wunsch systolic grid.
- Accepts alignment jobs (string pair) from NREQ requesters and picks one per job with round-robin arbitration.
- Loads the chosen pair onto the grid, sequences the grid clear/run phases, and waits for grid completion (score plus traceback) or a timeout.
- Returns the score to the winning requester with its ID. Sits between the request fabric and a single Grid instance.

Parameters:
- NREQ, 4, number of requesters (2..16)
- LENGTH, 10, characters per string (matches Grid LENGTH)
- CWIDTH, 2, bits per character
- SWIDTH, 16, bits per signed score
- CLEAR_CYCLES, 2, cycles grid_reset is held high per job (minimum 2)
- TIMEOUT, 4*LENGTH+16, RUN cycles allowed before abort
- IDW, clog2(NREQ), requester ID width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- req_valid  in  NREQ  per-requester job pending
- req_ready  out  NREQ  one-hot grant; job accepted when req_valid[i]&req_ready[i]
- req_s1  in  NREQ*LENGTH*CWIDTH  string 1 per requester; slice i at [i*LENGTH*CWIDTH +: LENGTH*CWIDTH]
- req_s2  in  NREQ*LENGTH*CWIDTH  string 2 per requester, same packing
- grid_reset  out  1  active-high reset to Grid
- grid_s1  out  LENGTH*CWIDTH  latched string 1 to Grid
- grid_s2  out  LENGTH*CWIDTH  latched string 2 to Grid
- grid_score  in  SWIDTH  Grid final score, signed
- grid_valid  in  1  Grid alignment and traceback complete
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  requester index of result
- rsp_score  out  SWIDTH  signed score; 0 on timeout
- rsp_timeout  out  1  job aborted by timeout
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_score=0, rsp_timeout=0, busy=0.
  - grid_reset=1; grid_s1 and grid_s2 are set to 0.
  - A reset during any phase aborts the job silently; no response is produced.
- States: IDLE, CLEAR, RUN, RESP.
- IDLE:
  - grid_reset=1.
  - If any req_valid is set, grant the first set bit searching from rr_ptr upward with wrap.
  - req_ready is combinational one-hot on the granted bit, asserted only in IDLE, so the grant lasts exactly 1 cycle.
  - On grant: latch the slices into grid_s1/grid_s2, store id, rr_ptr = (id+1) mod NREQ, cnt=0, go to CLEAR.
  - No req_valid set: stay in IDLE, rr_ptr unchanged.
- CLEAR:
  - grid_reset=1; cnt increments each cycle.
  - When cnt==CLEAR_CYCLES-1: cnt=0, go to RUN.
  - grid_valid is ignored in CLEAR, because the previous job's completion flag is still draining.
- RUN:
  - grid_reset=0; cnt increments each cycle.
  - If grid_valid==1: capture rsp_score=grid_score, set rsp_timeout=0, go to RESP.
  - Else if cnt==TIMEOUT-1: set rsp_score=0, rsp_timeout=1, go to RESP.
  - grid_valid takes priority over timeout when both occur in the same cycle.
- RESP:
  - rsp_valid=1; rsp_id, rsp_score and rsp_timeout are held stable until rsp_ready.
  - grid_reset=0, so the grid holds its result.
  - On rsp_valid&rsp_ready: rsp_valid=0, go to IDLE; grid_reset=1 from the next cycle.
- Latency: grant-to-rsp_valid = 1 + CLEAR_CYCLES + (cycles until grid_valid), registered.
- Fairness: a continuously requesting requester waits at most NREQ-1 other jobs.
- req_valid changes while not granted have no effect. The strings are sampled only on the grant cycle.
- cnt width: clog2(max(TIMEOUT, CLEAR_CYCLES)+1); it never wraps.

Decomposition:
- Package nw_pkg:
  - state encoding localparams (IDLE=0, CLEAR=1, RUN=2, RESP=3)
  - TOP/LEFT/CORNER direction codes
  - default MATCH/INDEL/MISMATCH weights
  - shared by Grid and this block.
- Sub-module nw_rr_arbiter:
  - inputs: req[NREQ], ptr, enable
  - outputs: gnt one-hot, gnt_id
  - purely combinational; rr_ptr stays in the sequencer.

Test Plan:
- Single job:
  - Stimulus: requester 2, s1=s2=all 0s, LENGTH=10; grid model asserts valid 30 cycles into RUN with score 10; rsp_ready=1.
  - Response: req_ready[2] pulses 1 cycle, grid_reset high 2 cycles, rsp_valid with rsp_id=2, rsp_score=10, rsp_timeout=0; rsp_valid falls the cycle after handshake.
- Round-robin:
  - Stimulus: req_valid=4'b1111 held.
  - Response: grants in order 0,1,2,3,0; drop req 1 after its first grant, then order 0,2,3,0,2.
- Backpressure:
  - Stimulus: rsp_ready=0 for 20 cycles in RESP, score -3.
  - Response: rsp_valid, rsp_id, rsp_score=-3 (0xFFFD) stable; no req_ready pulses until the handshake.
- Timeout:
  - Stimulus: grid_valid never asserts.
  - Response: rsp_valid after exactly 1+2+56 cycles from grant (TIMEOUT=56), rsp_timeout=1, rsp_score=0.
- Stale valid:
  - Stimulus: grid_valid held 1 during CLEAR.
  - Response: ignored; the job completes only on grid_valid seen in RUN.
- Reset mid-RUN:
  - Stimulus: reset=0 for 1 cycle.
  - Response: next cycle state IDLE, grid_reset=1, rsp_valid=0, busy=0, rr_ptr=0; the next grant goes to the lowest requesting index.
